// File: rtl/fft_stage_seq_pkg.sv
// Shared constants and FSM encoding for the radix-2 DIT FFT stage sequencer.
package fft_stage_seq_pkg;

  localparam int LOG2N_DEF  = 6;
  localparam int RD_LAT_DEF = 1;
  localparam int BF_LAT_DEF = 4;
  localparam int D_DEF      = RD_LAT_DEF + BF_LAT_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Read-to-write distance: RAM/ROM read plus butterfly pipeline.
  function automatic int pipe_depth(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction

endpackage

// File: rtl/fft_stage_seq_if.sv
// Control bundle between the FFT sequencer and the RAM/ROM/butterfly datapath.
interface fft_stage_seq_if
  import fft_stage_seq_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_stage_seq_delay.sv
// Valid-plus-payload shift register; reset flushes everything in flight.
module fft_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      dat_pipe[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_data = dat_pipe[DEPTH-1];
endmodule

// File: rtl/fft_stage_seq.sv
// In-place radix-2 DIT FFT address/control sequencer: one butterfly per cycle,
// writes retired D cycles after their reads, pipeline drained between stages.
module fft_stage_seq
  import fft_stage_seq_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input logic            clk,
  input logic            rst,
  fft_stage_seq_if.master bus
);
  localparam int D      = pipe_depth(RD_LAT, BF_LAT);
  localparam int HALF_N = 2 ** (LOG2N - 1);
  localparam int JW     = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int SW     = $clog2(LOG2N + 1);
  localparam int DW     = $clog2(D + 1);

  state_t          state, nxt;
  logic [JW-1:0]   j, j_n;
  logic [SW-1:0]   stage, stage_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            busy_q, done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      j      <= '0;
      stage  <= '0;
      dcnt   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      j      <= j_n;
      stage  <= stage_n;
      dcnt   <= dcnt_n;
      busy_q <= (nxt == ISSUE) || (nxt == DRAIN);
      done_q <= (nxt == FIN);
    end
  end

  always_comb begin
    nxt     = state;
    j_n     = j;
    stage_n = stage;
    dcnt_n  = dcnt;
    case (state)
      IDLE: if (bus.start) begin
        nxt     = ISSUE;
        j_n     = '0;
        stage_n = '0;
      end
      ISSUE: begin
        if (j == JW'(HALF_N - 1)) begin
          nxt    = DRAIN;
          j_n    = '0;
          dcnt_n = '0;
        end else begin
          j_n = j + 1'b1;
        end
      end
      DRAIN: begin
        // Hold off the next stage until every write of this one has retired.
        if (dcnt == DW'(D - 1)) begin
          if (stage == SW'(LOG2N - 1)) begin
            nxt = FIN;
          end else begin
            nxt     = ISSUE;
            stage_n = stage + 1'b1;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      FIN: begin
        nxt     = IDLE;
        stage_n = '0;
      end
      default: nxt = IDLE;
    endcase
  end

  // Butterfly pair: groups of 2*half, k within group, twiddle stride N/(2*half).
  logic [LOG2N-1:0] jx, half, k, a, b, twf;
  always_comb begin
    jx   = LOG2N'(j);
    half = LOG2N'(1) << stage;
    k    = jx & (half - LOG2N'(1));
    a    = ((jx >> stage) << (stage + SW'(1))) | k;
    b    = a | half;
    twf  = k << (SW'(LOG2N - 1) - stage);
  end

  logic             rd_en, wr_vld;
  logic [LOG2N-1:0] ra, rb;
  logic [2*LOG2N-1:0] wr_data;

  assign rd_en = (state == ISSUE);
  assign ra    = rd_en ? a : '0;
  assign rb    = rd_en ? b : '0;

  fft_delay_line #(.WIDTH(2 * LOG2N), .DEPTH(D)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_en),
    .in_data  ({ra, rb}),
    .out_vld  (wr_vld),
    .out_data (wr_data)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = ra;
  assign bus.rd_addr_b = rb;
  assign bus.tw_idx    = rd_en ? twf[LOG2N-2:0] : '0;
  assign bus.wr_en     = wr_vld;
  assign bus.wr_addr_a = wr_vld ? wr_data[2*LOG2N-1:LOG2N] : '0;
  assign bus.wr_addr_b = wr_vld ? wr_data[LOG2N-1:0] : '0;
endmodule

// File: tb/tb_fft_stage_seq.sv
// Bench for fft_stage_seq: cycle trace vs. a loop-built schedule, plus a real FFT run through the addresses.
module tb_fft_stage_seq;
  localparam int L    = 3;
  localparam int RDL  = 1;
  localparam int BFL  = 4;
  localparam int D    = RDL + BFL;
  localparam int N    = 1 << L;
  localparam int HN   = N / 2;
  localparam int PASS = L * (HN + D);
  localparam int LEN  = PASS + 3;
  localparam real PI  = 3.14159265358979323846;

  typedef struct packed {
    logic         rd_en;
    logic [L-1:0] ra;
    logic [L-1:0] rb;
    logic [L-2:0] tw;
    logic         wr_en;
    logic [L-1:0] wa;
    logic [L-1:0] wb;
    logic         busy;
    logic         done;
  } trace_t;

  typedef struct {
    real xr, xi, yr, yi;
  } bf_t;

  logic clk = 1'b0;
  logic rst;
  fft_stage_seq_if #(.LOG2N(L)) bus ();

  fft_stage_seq #(.LOG2N(L), .RD_LAT(RDL), .BF_LAT(BFL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  trace_t exp_tr [LEN];
  trace_t obs;

  function automatic trace_t snap();
    trace_t t;
    t.rd_en = bus.rd_en;
    t.ra    = bus.rd_addr_a;
    t.rb    = bus.rd_addr_b;
    t.tw    = bus.tw_idx;
    t.wr_en = bus.wr_en;
    t.wa    = bus.wr_addr_a;
    t.wb    = bus.wr_addr_b;
    t.busy  = bus.busy;
    t.done  = bus.done;
    return t;
  endfunction

  // Schedule relative to the start cycle (0): stage s owns cycles 1+s*(HN+D) ..
  task automatic build_expected();
    int half, j, t, a, b;
    for (int c = 0; c < LEN; c++) exp_tr[c] = '0;
    for (int c = 1; c <= PASS; c++) exp_tr[c].busy = 1'b1;
    exp_tr[PASS+1].done = 1'b1;
    for (int s = 0; s < L; s++) begin
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int k = 0; k < half; k++) begin
          j = g * half + k;
          t = 1 + s * (HN + D) + j;
          a = g * 2 * half + k;
          b = a + half;
          exp_tr[t].rd_en   = 1'b1;
          exp_tr[t].ra      = L'(a);
          exp_tr[t].rb      = L'(b);
          exp_tr[t].tw      = (L-1)'(k * (N / (2 * half)));
          exp_tr[t+D].wr_en = 1'b1;
          exp_tr[t+D].wa    = L'(a);
          exp_tr[t+D].wb    = L'(b);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    #2;
    obs = snap();
    checks++;
    if (obs !== trace_t'('0)) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", obs, trace_t'('0));
    end
    step();
    step();
    rst = 1'b0;
    step();
    obs = snap();
    checks++;
    if (obs !== trace_t'('0)) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", obs, trace_t'('0));
    end
  endtask

  task automatic test_single_pass();
    for (int c = 0; c < LEN; c++) begin
      obs = snap();
      checks++;
      if (obs !== exp_tr[c]) begin
        errors++;
        $display("FAIL single_pass c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
      end
      bus.start = (c == 0);
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_start_ignored();
    for (int c = 0; c < LEN; c++) begin
      obs = snap();
      checks++;
      if (obs !== exp_tr[c]) begin
        errors++;
        $display("FAIL start_ignored c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
      end
      bus.start = (c == 0) || (c == 5) || (c == 20) ||
                  (c >= 1 && c <= PASS && $urandom_range(3, 0) == 0);
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      obs = snap();
      checks++;
      if (obs !== exp_tr[c]) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
      end
      bus.start = (c == 0);
      step();
    end
    bus.start = 1'b0;
    // Now in cycle 8: reset for cycles 8 and 9, quiet through 11.
    rst = 1'b1;
    for (int c = 8; c < 12; c++) begin
      if (c == 10) rst = 1'b0;
      #1;
      obs = snap();
      checks++;
      if (obs !== trace_t'('0)) begin
        errors++;
        $display("FAIL reset_mid_flush c=%0d got=%h exp=%h", c, obs, trace_t'('0));
      end
      step();
    end
    for (int c = 0; c < LEN; c++) begin
      obs = snap();
      checks++;
      if (obs !== exp_tr[c]) begin
        errors++;
        $display("FAIL reset_mid_restart c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
      end
      bus.start = (c == 0);
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gap;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c <= PASS + 1; c++) begin
        obs = snap();
        checks++;
        if (obs !== exp_tr[c]) begin
          errors++;
          $display("FAIL back_to_back p=%0d c=%0d got=%h exp=%h", p, c, obs, exp_tr[c]);
        end
        bus.start = (c == 0);
        step();
      end
      bus.start = 1'b0;
      gap = (p == 0) ? 0 : int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        obs = snap();
        checks++;
        if (obs !== trace_t'('0)) begin
          errors++;
          $display("FAIL back_to_back_gap p=%0d g=%0d got=%h exp=%h", p, g, obs, trace_t'('0));
        end
        step();
      end
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < L; i++) if (v & (1 << i)) r |= 1 << (L - 1 - i);
    return r;
  endfunction

  // Drive a full FFT through the DUT's addresses; compare against a direct DFT.
  task automatic test_fft_numeric();
    real xr [N], xi [N], mr [N], mi [N];
    real cr, ci, tr, ti, er, ei;
    bf_t q [$];
    bf_t e;
    int  ia, ib, tw;
    bit  finished;
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < N; i++) begin
        if (run == 0) begin
          xr[i] = (i == 0) ? 1.0 : 0.0;
          xi[i] = 0.0;
        end else begin
          xr[i] = real'($urandom_range(2000, 0)) / 1000.0 - 1.0;
          xi[i] = real'($urandom_range(2000, 0)) / 1000.0 - 1.0;
        end
      end
      for (int i = 0; i < N; i++) begin
        mr[bitrev(i)] = xr[i];
        mi[bitrev(i)] = xi[i];
      end
      q.delete();
      finished  = 1'b0;
      bus.start = 1'b1;
      for (int c = 0; c < LEN + 5 && !finished; c++) begin
        step();
        bus.start = 1'b0;
        if (bus.rd_en) begin
          ia = int'(bus.rd_addr_a);
          ib = int'(bus.rd_addr_b);
          tw = int'(bus.tw_idx);
          cr = $cos(-2.0 * PI * tw / N);
          ci = $sin(-2.0 * PI * tw / N);
          tr = cr * mr[ib] - ci * mi[ib];
          ti = cr * mi[ib] + ci * mr[ib];
          e.xr = mr[ia] + tr;
          e.xi = mi[ia] + ti;
          e.yr = mr[ia] - tr;
          e.yi = mi[ia] - ti;
          q.push_back(e);
        end
        if (bus.wr_en) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fft_write_without_read run=%0d c=%0d", run, c);
          end else begin
            e = q.pop_front();
            mr[int'(bus.wr_addr_a)] = e.xr;
            mi[int'(bus.wr_addr_a)] = e.xi;
            mr[int'(bus.wr_addr_b)] = e.yr;
            mi[int'(bus.wr_addr_b)] = e.yi;
          end
        end
        if (bus.done) finished = 1'b1;
      end
      if (!finished) begin
        checks++;
        errors++;
        $display("FAIL fft_done_timeout run=%0d got=0 exp=1", run);
      end
      for (int k = 0; k < N; k++) begin
        er = 0.0;
        ei = 0.0;
        for (int n = 0; n < N; n++) begin
          er += xr[n] * $cos(2.0 * PI * n * k / N) + xi[n] * $sin(2.0 * PI * n * k / N);
          ei += xi[n] * $cos(2.0 * PI * n * k / N) - xr[n] * $sin(2.0 * PI * n * k / N);
        end
        checks++;
        if ((mr[k] - er) > 1e-9 || (er - mr[k]) > 1e-9 ||
            (mi[k] - ei) > 1e-9 || (ei - mi[k]) > 1e-9) begin
          errors++;
          $display("FAIL fft_bin run=%0d k=%0d got=(%f,%f) exp=(%f,%f)", run, k, mr[k], mi[k], er, ei);
        end
      end
      step();
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    build_expected();
    test_reset();
    test_single_pass();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_fft_numeric();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end
endmodule
